// File: rtl/vfu_mask_router_pkg.sv
// Shared types for the per-lane mask router. This covers the mask-unit target
// selector and the request record that the router queues for each instruction.
package vfu_mask_router_pkg;

    localparam int unsigned DefQueueDepth = 4;
    localparam int unsigned BeatCntWidth  = 16;
    localparam int unsigned NrVInsn       = 8;
    localparam int unsigned StrbWidth     = 8;

    typedef logic [$clog2(NrVInsn)-1:0] vid_t;
    typedef logic [StrbWidth-1:0]       strb_t;
    typedef logic [BeatCntWidth-1:0]    beat_cnt_t;

    typedef enum logic {
        MaskRouteAlu  = 1'b0,
        MaskRouteMfpu = 1'b1
    } mask_fu_e;

    typedef struct packed {
        mask_fu_e  fu;
        vid_t      id;
        beat_cnt_t beats;
    } mask_route_req_t;

endpackage

// File: rtl/vfu_mask_router_fifo.sv
// Registered-output FIFO with no fall-through. It holds the outstanding masked
// instructions in issue order.
module vfu_mask_router_fifo #(
    parameter int unsigned Depth = 4,
    parameter type dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] occ_q;
    dtype            mem_q [Depth];
    logic            do_push, do_pop;

    assign full_o  = (occ_q == CntW'(Depth));
    assign empty_o = (occ_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + CntW'(1);
                2'b01:   occ_q <= occ_q - CntW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/vfu_mask_router.sv
// Steers mask-unit beats to the ALU or the MFPU, according to the oldest queued
// masked instruction, and retires that instruction once its beat budget is used up.
module vfu_mask_router
    import vfu_mask_router_pkg::*;
#(
    parameter int unsigned QueueDepth = DefQueueDepth
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      issue_valid_i,
    output logic      issue_ready_o,
    input  mask_fu_e  issue_fu_i,
    input  vid_t      issue_id_i,
    input  beat_cnt_t issue_beats_i,
    input  strb_t     mask_i,
    input  logic      mask_valid_i,
    output logic      mask_ready_o,
    output strb_t     alu_mask_o,
    output logic      alu_mask_valid_o,
    input  logic      alu_mask_ready_i,
    output strb_t     mfpu_mask_o,
    output logic      mfpu_mask_valid_o,
    input  logic      mfpu_mask_ready_i,
    output logic      done_valid_o,
    output vid_t      done_id_o,
    output logic      busy_o
);

    // Handshakes: a transfer happens on a rising clock edge when valid and ready
    // are both high. Valid does not depend on ready. The producer holds the data
    // stable until the transfer occurs.
    mask_route_req_t issue_req, head;
    logic            full, empty, push, pop, beat_hs, head_alu;
    beat_cnt_t       cnt_q, cnt_inc;
    logic            done_valid_q;
    vid_t            done_id_q;

    assign issue_req = '{fu: issue_fu_i, id: issue_id_i, beats: issue_beats_i};

    // Zero-beat registrations complete the handshake but have nothing to retire.
    assign issue_ready_o = ~full;
    assign push          = issue_valid_i & issue_ready_o & (issue_beats_i != '0);

    vfu_mask_router_fifo #(
        .Depth (QueueDepth),
        .dtype (mask_route_req_t)
    ) i_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (issue_req),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head_alu          = (head.fu == MaskRouteAlu);
    assign alu_mask_o        = mask_i;
    assign mfpu_mask_o       = mask_i;
    assign alu_mask_valid_o  = mask_valid_i & ~empty & head_alu;
    assign mfpu_mask_valid_o = mask_valid_i & ~empty & ~head_alu;
    assign mask_ready_o      = ~empty & (head_alu ? alu_mask_ready_i : mfpu_mask_ready_i);

    assign beat_hs = mask_valid_i & mask_ready_o;
    assign cnt_inc = cnt_q + beat_cnt_t'(1);
    assign pop     = beat_hs & (cnt_inc == head.beats);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
        end else begin
            if (pop)          cnt_q <= '0;
            else if (beat_hs) cnt_q <= cnt_inc;
            done_valid_q <= pop;
            if (pop) done_id_q <= head.id;
        end
    end

    assign done_valid_o = done_valid_q;
    assign done_id_o    = done_id_q;
    assign busy_o       = ~empty;

endmodule

// File: tb/tb_vfu_mask_router.sv
// Directed bench for vfu_mask_router. Expected beats and done ids are queued
// when stimulus is issued, and a negedge monitor pops them when the DUT presents an output.
module tb_vfu_mask_router;
    import vfu_mask_router_pkg::*;

    logic      clk_i = 1'b0;
    logic      rst_ni = 1'b0;
    logic      issue_valid_i = 1'b0;
    logic      issue_ready_o;
    mask_fu_e  issue_fu_i = MaskRouteAlu;
    vid_t      issue_id_i = '0;
    beat_cnt_t issue_beats_i = '0;
    strb_t     mask_i = 8'hA5;
    logic      mask_valid_i = 1'b0;
    logic      mask_ready_o;
    strb_t     alu_mask_o, mfpu_mask_o;
    logic      alu_mask_valid_o, mfpu_mask_valid_o;
    logic      alu_mask_ready_i = 1'b1;
    logic      mfpu_mask_ready_i = 1'b1;
    logic      done_valid_o;
    vid_t      done_id_o;
    logic      busy_o;

    int checks = 0;
    int errors = 0;

    strb_t alu_exp_q[$];
    strb_t mfpu_exp_q[$];
    vid_t  done_exp_q[$];

    vfu_mask_router dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_fu_i        (issue_fu_i),
        .issue_id_i        (issue_id_i),
        .issue_beats_i     (issue_beats_i),
        .mask_i            (mask_i),
        .mask_valid_i      (mask_valid_i),
        .mask_ready_o      (mask_ready_o),
        .alu_mask_o        (alu_mask_o),
        .alu_mask_valid_o  (alu_mask_valid_o),
        .alu_mask_ready_i  (alu_mask_ready_i),
        .mfpu_mask_o       (mfpu_mask_o),
        .mfpu_mask_valid_o (mfpu_mask_valid_o),
        .mfpu_mask_ready_i (mfpu_mask_ready_i),
        .done_valid_o      (done_valid_o),
        .done_id_o         (done_id_o),
        .busy_o            (busy_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    // driver tasks: they start and end 1 time unit after a rising edge
    task automatic issue(input mask_fu_e fu, input vid_t id, input beat_cnt_t beats);
        int   n = 0;
        logic ok = 1'b0;
        issue_valid_i = 1'b1;
        issue_fu_i    = fu;
        issue_id_i    = id;
        issue_beats_i = beats;
        forever begin
            @(negedge clk_i);
            ok = issue_ready_o;
            next();
            if (ok) break;
            n++;
            if (n > 50) begin
                fail("issue_timeout", {29'd0, id});
                break;
            end
        end
        issue_valid_i = 1'b0;
        if (ok && beats != '0) done_exp_q.push_back(id);
    endtask

    task automatic send_beat(input strb_t val, input mask_fu_e dest, output int stalls);
        logic ok = 1'b0;
        stalls = 0;
        mask_i       = val;
        mask_valid_i = 1'b1;
        if (dest == MaskRouteAlu) alu_exp_q.push_back(val);
        else                      mfpu_exp_q.push_back(val);
        forever begin
            @(negedge clk_i);
            ok = mask_ready_o;
            next();
            if (ok) break;
            stalls++;
            if (stalls > 50) begin
                fail("beat_timeout", {24'd0, val});
                break;
            end
        end
        mask_valid_i = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("valid_onehot", {31'd0, alu_mask_valid_o & mfpu_mask_valid_o}, 32'd0);
            if (alu_mask_valid_o && alu_mask_ready_i) begin
                if (alu_exp_q.size() == 0) fail("alu_beat_unexpected", {24'd0, alu_mask_o});
                else check("alu_beat", {24'd0, alu_mask_o}, {24'd0, alu_exp_q.pop_front()});
            end
            if (mfpu_mask_valid_o && mfpu_mask_ready_i) begin
                if (mfpu_exp_q.size() == 0) fail("mfpu_beat_unexpected", {24'd0, mfpu_mask_o});
                else check("mfpu_beat", {24'd0, mfpu_mask_o}, {24'd0, mfpu_exp_q.pop_front()});
            end
            if (done_valid_o) begin
                if (done_exp_q.size() == 0) fail("done_unexpected", {29'd0, done_id_o});
                else check("done_id", {29'd0, done_id_o}, {29'd0, done_exp_q.pop_front()});
            end
        end
    end

    initial begin
        int st;

        // reset state, with mask_i = A5 passing straight through
        #2;
        check("rst_issue_ready", issue_ready_o, 1);
        check("rst_mask_ready", mask_ready_o, 0);
        check("rst_alu_valid", alu_mask_valid_o, 0);
        check("rst_mfpu_valid", mfpu_mask_valid_o, 0);
        check("rst_done_valid", done_valid_o, 0);
        check("rst_done_id", done_id_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_alu_mask", alu_mask_o, 8'hA5);
        check("rst_mfpu_mask", mfpu_mask_o, 8'hA5);
        #10 rst_ni = 1'b1;
        next();

        // single ALU entry id=2 beats=3
        issue(MaskRouteAlu, 3'd2, 16'd3);
        @(negedge clk_i); check("t1_busy", busy_o, 1); next();
        send_beat(8'hFF, MaskRouteAlu, st);
        send_beat(8'h0F, MaskRouteAlu, st);
        send_beat(8'h01, MaskRouteAlu, st);
        @(negedge clk_i);
        check("t1_done_valid", done_valid_o, 1);
        check("t1_done_id", done_id_o, 2);
        next();
        @(negedge clk_i);
        check("t1_done_pulse_end", done_valid_o, 0);
        check("t1_busy_after", busy_o, 0);
        next();

        // back-to-back ALU id=1 beats=2, then MFPU id=4 beats=1
        issue(MaskRouteAlu, 3'd1, 16'd2);
        issue(MaskRouteMfpu, 3'd4, 16'd1);
        send_beat(8'h11, MaskRouteAlu, st);
        send_beat(8'h22, MaskRouteAlu, st);
        send_beat(8'h33, MaskRouteMfpu, st);
        check("t2_no_bubble", st, 0);
        @(negedge clk_i); check("t2_done_id", done_id_o, 4); next();

        // backpressure on the ALU head
        alu_mask_ready_i = 1'b0;
        issue(MaskRouteAlu, 3'd5, 16'd2);
        mask_i = 8'h5A;
        mask_valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            check("t3_mask_ready_low", mask_ready_o, 0);
            check("t3_alu_valid", alu_mask_valid_o, 1);
            check("t3_mfpu_valid", mfpu_mask_valid_o, 0);
            check("t3_no_done", done_valid_o, 0);
            next();
        end
        alu_mask_ready_i = 1'b1;
        alu_exp_q.push_back(8'h5A);
        @(negedge clk_i); check("t3_mask_ready_high", mask_ready_o, 1); next();
        mask_valid_i = 1'b0;
        @(negedge clk_i); check("t3_no_early_done", done_valid_o, 0); next();
        send_beat(8'hA5, MaskRouteAlu, st);
        @(negedge clk_i); check("t3_done_id", done_id_o, 5); next();

        // full queue: four single-beat entries, then a fifth issue stalls
        for (int i = 0; i < 4; i++) issue(MaskRouteAlu, vid_t'(i), 16'd1);
        issue_valid_i = 1'b1;
        issue_fu_i    = MaskRouteMfpu;
        issue_id_i    = 3'd6;
        issue_beats_i = 16'd1;
        repeat (2) begin
            @(negedge clk_i); check("t4_full_ready", issue_ready_o, 0); next();
        end
        mask_i = 8'hC3;
        mask_valid_i = 1'b1;
        alu_exp_q.push_back(8'hC3);
        @(negedge clk_i);
        check("t4_pop_beat_ready", mask_ready_o, 1);
        check("t4_ready_not_pop_aware", issue_ready_o, 0);
        next();
        mask_valid_i = 1'b0;
        @(negedge clk_i); check("t4_ready_after_pop", issue_ready_o, 1); next();
        issue_valid_i = 1'b0;
        done_exp_q.push_back(3'd6);
        @(negedge clk_i); check("t4_full_again", issue_ready_o, 0); next();
        send_beat(8'h01, MaskRouteAlu, st);
        send_beat(8'h02, MaskRouteAlu, st);
        send_beat(8'h03, MaskRouteAlu, st);
        send_beat(8'h06, MaskRouteMfpu, st);
        next();
        @(negedge clk_i); check("t4_drained", busy_o, 0); next();

        // zero-beat registration and beats offered to an empty queue
        issue(MaskRouteAlu, 3'd7, 16'd0);
        repeat (2) begin
            @(negedge clk_i); check("t5_busy_zero", busy_o, 0); next();
        end
        mask_i = 8'h77;
        mask_valid_i = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            check("t5_empty_mask_ready", mask_ready_o, 0);
            check("t5_empty_alu_valid", alu_mask_valid_o, 0);
            check("t5_empty_mfpu_valid", mfpu_mask_valid_o, 0);
            next();
        end
        mask_valid_i = 1'b0;

        // reset in the middle of an MFPU entry beats=4
        issue(MaskRouteMfpu, 3'd3, 16'd4);
        send_beat(8'h10, MaskRouteMfpu, st);
        send_beat(8'h20, MaskRouteMfpu, st);
        mask_i = 8'h30;
        mask_valid_i = 1'b1;
        #1 check("t6_pre_rst_mfpu_valid", mfpu_mask_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_issue_ready", issue_ready_o, 1);
        check("t6_rst_mask_ready", mask_ready_o, 0);
        check("t6_rst_mfpu_valid", mfpu_mask_valid_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_done", done_valid_o, 0);
        mask_valid_i = 1'b0;
        done_exp_q.delete();
        next();
        #2 rst_ni = 1'b1;
        next();
        issue(MaskRouteAlu, 3'd1, 16'd1);
        send_beat(8'h44, MaskRouteAlu, st);
        @(negedge clk_i);
        check("t6_done_valid", done_valid_o, 1);
        check("t6_done_id", done_id_o, 1);
        next();
        repeat (3) next();

        check("alu_q_left", alu_exp_q.size(), 0);
        check("mfpu_q_left", mfpu_exp_q.size(), 0);
        check("done_q_left", done_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
